// File: rtl/fifo_consumer_pkg.sv
// State encoding for fifo_consumer: one-hot enum plus the bit index of each state.
package fifo_consumer_pkg;

    localparam int unsigned STATE_W = 5;

    localparam int unsigned IDLE_B  = 0;
    localparam int unsigned WAIT_B  = 1;
    localparam int unsigned BURST_B = 2;
    localparam int unsigned DRAIN_B = 3;
    localparam int unsigned DONE_B  = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 5'b00001,
        StWait  = 5'b00010,
        StBurst = 5'b00100,
        StDrain = 5'b01000,
        StDone  = 5'b10000
    } fifo_consumer_state_t;

endpackage

// File: rtl/single_port_ram_pkg.sv
// Control encodings shared by every client of the single-port buffer SRAM.
package single_port_ram_pkg;

    localparam logic CS_ENB   = 1'b1;
    localparam logic CS_DIS   = 1'b0;
    localparam logic OE_ENB   = 1'b1;
    localparam logic OE_DIS   = 1'b0;
    localparam logic WREQ_ENB = 1'b1;
    localparam logic WREQ_DIS = 1'b0;

endpackage

// File: rtl/fifo_consumer.sv
// Drains a sync FIFO into the buffer SRAM over an address range, in arbiter-granted bursts.
// Define FIFO_CONSUMER_STALL_CNT_EN to add the stall_cnt port (empty-FIFO cycles inside a burst).
module fifo_consumer
    import fifo_consumer_pkg::*;
    import single_port_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BURST_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enb,
    output logic                  done,
    output logic                  request,
    input  logic                  grant,
    input  logic [ADDR_WIDTH-1:0] addr_begin,
    input  logic [ADDR_WIDTH-1:0] addr_step,
    input  logic [ADDR_WIDTH-1:0] addr_end,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  to_buffer_cs,
    output logic                  to_buffer_oe,
    output logic [ADDR_WIDTH-1:0] to_buffer_addr,
    output logic                  to_buffer_W_req,
`ifdef FIFO_CONSUMER_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0] to_buffer_W_data
);

    localparam int unsigned CNT_W = $clog2(BURST_SIZE + 1);

    fifo_consumer_state_t  state_q, state_d;
    logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  last_issued_q, last_issued_d;
    logic [CNT_W-1:0]      pop_cnt_q, pop_cnt_d;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pop;
    logic                  final_pop;

    assign pop = state_q[BURST_B] && !fifo_empty && !last_issued_q &&
                 (pop_cnt_q < CNT_W'(BURST_SIZE));
    assign final_pop = pop && ((pop_cnt_q == CNT_W'(BURST_SIZE - 1)) || (issue_addr_q == addr_end));

    always_comb begin
        state_d       = state_q;
        issue_addr_d  = issue_addr_q;
        last_issued_d = last_issued_q;
        pop_cnt_d     = pop_cnt_q;
        request       = 1'b0;
        done          = 1'b0;
        unique case (1'b1)
            state_q[IDLE_B]: begin
                if (enb) begin
                    state_d       = StWait;
                    issue_addr_d  = addr_begin;
                    last_issued_d = 1'b0;
                end
            end
            state_q[WAIT_B]: begin
                request = !fifo_empty;
                if (grant && !fifo_empty) begin
                    state_d = StBurst;
                end
            end
            state_q[BURST_B]: begin
                request = 1'b1;
                if (pop) begin
                    pop_cnt_d     = pop_cnt_q + CNT_W'(1);
                    issue_addr_d  = issue_addr_q + addr_step;
                    last_issued_d = (issue_addr_q == addr_end);
                end
                if (final_pop) begin
                    state_d = StDrain;
                end
            end
            state_q[DRAIN_B]: begin
                // The bus stays held while the last popped word is written.
                request   = 1'b1;
                pop_cnt_d = '0;
                state_d   = last_issued_q ? StDone : StWait;
            end
            state_q[DONE_B]: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        if (state_q[IDLE_B] && enb) begin
            wr_addr_d = addr_begin;
        end else if (vld_q) begin
            wr_addr_d = wr_addr_q + addr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            issue_addr_q  <= '0;
            wr_addr_q     <= '0;
            last_issued_q <= 1'b0;
            pop_cnt_q     <= '0;
            vld_q         <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            issue_addr_q  <= issue_addr_d;
            wr_addr_q     <= wr_addr_d;
            last_issued_q <= last_issued_d;
            pop_cnt_q     <= pop_cnt_d;
            vld_q         <= pop;
            if (vld_q) begin
                data_q <= fifo_data_out;
            end
        end
    end

    assign fifo_r_en        = pop;
    assign to_buffer_cs     = vld_q ? CS_ENB : CS_DIS;
    assign to_buffer_W_req  = vld_q ? WREQ_ENB : WREQ_DIS;
    assign to_buffer_oe     = OE_DIS;
    assign to_buffer_addr   = wr_addr_q;
    // Read data arrives one cycle after the pop, exactly when the write slot opens.
    assign to_buffer_W_data = vld_q ? fifo_data_out : data_q;

`ifdef FIFO_CONSUMER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (state_q[IDLE_B] && enb) begin
            stall_cnt_q <= '0;
        end else if (state_q[BURST_B] && fifo_empty && !last_issued_q && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
